// File: rtl/qpu_exu_wbck_arb_pkg.sv
// qpu_exu_wbck_arb_pkg
//  Shared constants and helpers for the EXU write-back arbiter:
//   - default starvation threshold and time/event queue depth
//   - clog2 helper (elaboration-time)
//   - time/event queue entry width: {t, e, time, evw, oprand}
package qpu_exu_wbck_arb_pkg;

  localparam int STARVE_MAX_DEF = 4;
  localparam int WQ_DEPTH_DEF   = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // two flag bits (t, e) plus the three payload fields
  function automatic int wq_ent_w(input int tw, input int ew, input int en);
    return tw + ew + en + 2;
  endfunction

endpackage

// File: rtl/qpu_exu_wbck_arb_if.sv
// qpu_exu_wbck_arb_if
//  Bundles every write-back signal of the arbiter.
//  slave  : the arbiter side (takes requests, drives CRF/TRF/ERF/TIQ/EVQ writes)
//  master : the environment side (ALU/long-pipe sources and the downstream sinks)
//  Classical: cwbck_i_valid/ready/data/rdidx (NSRC sources, packed), crf_wbck_o_*
//  Time/event: alu_twbck_i_*, alu_ewbck_i_*, alu_tewbck_i_ready,
//              trf/erf/tiq/evq_wbck_o_*, tiq_wbck_o_ready, evq_wbck_o_ready
interface qpu_exu_wbck_arb_if #(
  parameter int NSRC    = 2,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int TIME_W  = 32,
  parameter int EVW_W   = 32,
  parameter int EVN     = 8
);
  logic [NSRC-1:0]         cwbck_i_valid;
  logic [NSRC-1:0]         cwbck_i_ready;
  logic [NSRC*XLEN-1:0]    cwbck_i_data;
  logic [NSRC*RFIDX_W-1:0] cwbck_i_rdidx;

  logic                    alu_twbck_i_valid;
  logic [TIME_W-1:0]       alu_twbck_i_data;
  logic                    alu_ewbck_i_valid;
  logic [EVW_W-1:0]        alu_ewbck_i_data;
  logic [EVN-1:0]          alu_ewbck_i_oprand;
  logic                    alu_tewbck_i_ready;

  logic                    crf_wbck_o_ena;
  logic [XLEN-1:0]         crf_wbck_o_data;
  logic [RFIDX_W-1:0]      crf_wbck_o_rdidx;
  logic                    trf_wbck_o_ena;
  logic [TIME_W-1:0]       trf_wbck_o_data;
  logic                    erf_wbck_o_ena;
  logic [EVW_W-1:0]        erf_wbck_o_data;
  logic [EVN-1:0]          erf_wbck_o_oprand;
  logic                    tiq_wbck_o_ena;
  logic [TIME_W-1:0]       tiq_wbck_o_data;
  logic                    tiq_wbck_o_ready;
  logic                    evq_wbck_o_ena;
  logic                    evq_wbck_o_ready;

  modport slave (
    input  cwbck_i_valid, cwbck_i_data, cwbck_i_rdidx,
    output cwbck_i_ready,
    input  alu_twbck_i_valid, alu_twbck_i_data,
    input  alu_ewbck_i_valid, alu_ewbck_i_data, alu_ewbck_i_oprand,
    output alu_tewbck_i_ready,
    output crf_wbck_o_ena, crf_wbck_o_data, crf_wbck_o_rdidx,
    output trf_wbck_o_ena, trf_wbck_o_data,
    output erf_wbck_o_ena, erf_wbck_o_data, erf_wbck_o_oprand,
    output tiq_wbck_o_ena, tiq_wbck_o_data, evq_wbck_o_ena,
    input  tiq_wbck_o_ready, evq_wbck_o_ready
  );

  modport master (
    output cwbck_i_valid, cwbck_i_data, cwbck_i_rdidx,
    input  cwbck_i_ready,
    output alu_twbck_i_valid, alu_twbck_i_data,
    output alu_ewbck_i_valid, alu_ewbck_i_data, alu_ewbck_i_oprand,
    input  alu_tewbck_i_ready,
    input  crf_wbck_o_ena, crf_wbck_o_data, crf_wbck_o_rdidx,
    input  trf_wbck_o_ena, trf_wbck_o_data,
    input  erf_wbck_o_ena, erf_wbck_o_data, erf_wbck_o_oprand,
    input  tiq_wbck_o_ena, tiq_wbck_o_data, evq_wbck_o_ena,
    output tiq_wbck_o_ready, evq_wbck_o_ready
  );
endinterface

// File: rtl/qpu_wbck_fifo.sv
// qpu_wbck_fifo
//  DEPTH-entry (power of two) valid/ready FIFO with async-reset pointers.
//  Pointers carry one extra wrap bit so full/empty are told apart.
//  A push is accepted when full if a pop happens in the same cycle.
//  Ports: clk, rst_n, in_valid_i/in_ready_o/in_data_i, out_valid_o/out_ready_i/out_data_o
module qpu_wbck_fifo
  import qpu_exu_wbck_arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);
  localparam int AW = clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [AW:0]              wr_q, rd_q;
  logic                     empty, full, push, pop;

  assign empty       = (wr_q == rd_q);
  assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign out_valid_o = ~empty;
  assign out_data_o  = mem_q[rd_q[AW-1:0]];
  // a pop in the same cycle frees the head slot before the push lands
  assign in_ready_o  = ~full | out_ready_i;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_data_i;
  end
endmodule

// File: rtl/qpu_exu_wbck_arb.sv
// qpu_exu_wbck_arb
//  EXU write-back arbiter.
//  Classical path: NSRC sources share the CRF write port; fixed priority (0 highest)
//  with per-source wait counters that force a grant after STARVE_MAX waiting cycles.
//  Time/event path: WQ_DEPTH-entry queue toward TRF/ERF/TIQ/EVQ.
//  Optional macro QPU_WBCK_BYPASS_EN: an entry arriving at an empty queue with
//  TIQ/EVQ ready goes straight to the outputs in the same cycle.
//  Ports: clk, rst_n (async active-low), bus (qpu_exu_wbck_arb_if.slave)
module qpu_exu_wbck_arb
  import qpu_exu_wbck_arb_pkg::*;
#(
  parameter int NSRC       = 2,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int TIME_W     = 32,
  parameter int EVW_W      = 32,
  parameter int EVN        = 8,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int WQ_DEPTH   = WQ_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  qpu_exu_wbck_arb_if.slave  bus
);
  localparam int CW = clog2(STARVE_MAX + 1);
  localparam int EW = wq_ent_w(TIME_W, EVW_W, EVN);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

  // ---------------- classical path ----------------
  logic [NSRC-1:0][CW-1:0] wait_q, wait_d;
  logic [NSRC-1:0]         gnt;
  logic                    hit;
  logic [XLEN-1:0]         crf_data;
  logic [RFIDX_W-1:0]      crf_idx;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    // starved sources first, then plain fixed priority
    for (int k = 0; k < NSRC; k++)
      if (!hit && bus.cwbck_i_valid[k] && wait_q[k] == CMAX) begin
        gnt[k] = 1'b1;
        hit    = 1'b1;
      end
    for (int k = 0; k < NSRC; k++)
      if (!hit && bus.cwbck_i_valid[k]) begin
        gnt[k] = 1'b1;
        hit    = 1'b1;
      end
    if (!rst_n) gnt = '0;
  end

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      if (!bus.cwbck_i_valid[k] || gnt[k]) wait_d[k] = '0;
      else if (wait_q[k] != CMAX)          wait_d[k] = wait_q[k] + 1'b1;
      else                                 wait_d[k] = wait_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  always_comb begin
    crf_data = '0;
    crf_idx  = '0;
    for (int k = 0; k < NSRC; k++)
      if (gnt[k]) begin
        crf_data = bus.cwbck_i_data[k*XLEN +: XLEN];
        crf_idx  = bus.cwbck_i_rdidx[k*RFIDX_W +: RFIDX_W];
      end
  end

  assign bus.cwbck_i_ready    = gnt;
  assign bus.crf_wbck_o_ena   = |gnt;
  assign bus.crf_wbck_o_data  = crf_data;
  assign bus.crf_wbck_o_rdidx = crf_idx;

  // ---------------- time/event path ----------------
  // entry layout {t, e, time, evw, oprand}
  localparam int OP_LO = 0;
  localparam int EV_LO = EVN;
  localparam int TM_LO = EVN + EVW_W;

  logic          te_vld, sink_rdy, fire, byp;
  logic          fifo_in_vld, fifo_in_rdy, fifo_out_vld;
  logic [EW-1:0] te_ent, head, out_ent;

  assign te_vld   = bus.alu_twbck_i_valid | bus.alu_ewbck_i_valid;
  assign sink_rdy = bus.tiq_wbck_o_ready & bus.evq_wbck_o_ready;
  assign te_ent   = {bus.alu_twbck_i_valid, bus.alu_ewbck_i_valid, bus.alu_twbck_i_data,
                     bus.alu_ewbck_i_data, bus.alu_ewbck_i_oprand};

`ifdef QPU_WBCK_BYPASS_EN
  assign byp = rst_n & te_vld & ~fifo_out_vld & sink_rdy;
`else
  assign byp = 1'b0;
`endif

  assign fifo_in_vld = te_vld & ~byp;

  qpu_wbck_fifo #(.DW(EW), .DEPTH(WQ_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (fifo_in_vld),
    .in_ready_o (fifo_in_rdy),
    .in_data_i  (te_ent),
    .out_valid_o(fifo_out_vld),
    .out_ready_i(sink_rdy),
    .out_data_o (head)
  );

  assign out_ent = byp ? te_ent : head;
  assign fire    = rst_n & (byp | (fifo_out_vld & sink_rdy));

  assign bus.alu_tewbck_i_ready = rst_n & fifo_in_rdy;
  // every stored entry has t or e set, so this is the plain pop strobe
  assign bus.erf_wbck_o_ena     = fire & (out_ent[EW-1] | out_ent[EW-2]);
  assign bus.trf_wbck_o_ena     = fire & out_ent[EW-1];
  assign bus.tiq_wbck_o_ena     = fire & out_ent[EW-1];
  assign bus.evq_wbck_o_ena     = fire & out_ent[EW-1];
  assign bus.trf_wbck_o_data    = fire ? out_ent[TM_LO +: TIME_W] : '0;
  assign bus.tiq_wbck_o_data    = fire ? out_ent[TM_LO +: TIME_W] : '0;
  assign bus.erf_wbck_o_data    = fire ? out_ent[EV_LO +: EVW_W]  : '0;
  assign bus.erf_wbck_o_oprand  = fire ? out_ent[OP_LO +: EVN]    : '0;
endmodule
